popcount_thermo_serializer: RTL

- Inverse of the 8-input ones-counter: takes a population count presented as {cout, sum[2:0]} and regenerates an 8-bit word with exactly that many ones, in thermometer order (bit 0 first).
- Emits the word serially, one bit per clock, on the d0..d7 bit ordering.
- Presents the completed word in parallel at the end of each frame.
- Sits downstream of the adder/counter blocks as a stimulus and loopback source: serializer output re-counted by the adder must equal the input count.

---
 rtl/popcount_thermo_serializer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/popcount_thermo_serializer.sv
// popcount_thermo_serializer
//
// Purpose:
//   Turns a population count {in_cout, in_sum} back into an 8-bit word
//   holding exactly that many ones in thermometer order (bit 0 first).
//   The word goes out serially, one bit per clock, in d0..d7 order. At the
//   end of each frame the completed word is also presented in parallel.
//   Counts above WIDTH saturate to WIDTH and raise a one-cycle sat_err.
//   Because the serial stream carries exactly cnt ones, feeding it back into
//   an 8-input ones-counter returns the original (saturated) count.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a count is being offered
//   in_ready   block can accept a count (high only while IDLE)
//   in_sum     low CNT_W-1 bits of the count
//   in_cout    MSB of the count; count = {in_cout, in_sum}
//   ser_bit    serial thermometer bit
//   ser_valid  ser_bit is valid this cycle
//   ser_last   marks the final bit (index WIDTH-1) of a frame
//   par_word   completed thermometer word, held between frames
//   par_valid  one-cycle pulse: par_word was just updated
//   sat_err    one-cycle pulse with the first serial bit: count exceeded WIDTH
//
// Frame timing (accept on edge 0):
//   cycles 1..WIDTH : ser_valid=1, ser_bit = (idx < cnt)
//   cycle  WIDTH+1  : par_valid=1, par_word updated
//   cycle  WIDTH+2  : back in IDLE, in_ready=1

module popcount_thermo_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-2:0]   in_sum,
  input  logic               in_cout,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               ser_last,
  output logic [WIDTH-1:0]   par_word,
  output logic               par_valid,
  output logic               sat_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic               par_valid_q, par_valid_d;
  logic               sat_err_q, sat_err_d;
  logic [WIDTH-1:0]   par_word_q, par_word_d;

  logic [CNT_W-1:0]   count_in;
  logic               count_over;
  logic [CNT_W-1:0]   count_sat;
  logic [CNT_W-1:0]   idx_inc;

  // Thermometer code: bit i set when i is below the count, so a count of
  // WIDTH sets every bit (same as (1 << c) - 1 without overflow concerns).
  function automatic logic [WIDTH-1:0] thermo(input logic [CNT_W-1:0] c);
    logic [WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = (CNT_W'(i) < c);
    end
    return t;
  endfunction

  // Incoming count with saturation applied before it is latched.
  always_comb begin
    count_in   = {in_cout, in_sum};
    count_over = (count_in > MAX_CNT);
    count_sat  = count_over ? MAX_CNT : count_in;
    idx_inc    = idx_q + CNT_W'(1);
  end

  // Next-state and registered-output computation. Output flops default to
  // their idle values so every pulse lasts exactly one cycle; par_word is
  // the only output that holds its value between frames.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ser_bit_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    par_valid_d = 1'b0;
    sat_err_d   = 1'b0;
    par_word_d  = par_word_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // The first serial bit is produced on the accept edge itself,
          // giving one cycle of latency to the first ser_valid.
          state_d     = SHIFT;
          idx_d       = '0;
          cnt_d       = count_sat;
          ser_valid_d = 1'b1;
          ser_bit_d   = (count_sat != '0);
          ser_last_d  = (LAST_IDX == '0);
          sat_err_d   = count_over;
        end
      end

      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          par_valid_d = 1'b1;
          par_word_d  = thermo(cnt_q);
        end else begin
          idx_d       = idx_inc;
          ser_valid_d = 1'b1;
          ser_bit_d   = (idx_inc < cnt_q);
          ser_last_d  = (idx_inc == LAST_IDX);
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress and
  // clears the held parallel word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      par_valid_q <= 1'b0;
      sat_err_q   <= 1'b0;
      par_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      par_valid_q <= par_valid_d;
      sat_err_q   <= sat_err_d;
      par_word_q  <= par_word_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign par_valid = par_valid_q;
  assign sat_err   = sat_err_q;
  assign par_word  = par_word_q;

endmodule
